// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the configurable serial pattern detector.
package seq_det_pkg;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // Limit a requested pattern length to what the history register can hold.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register, fill counter and length-masked pattern compare.
// The hit output reflects the state the window is about to move into, so a
// detection is flagged on the same edge that consumes the final pattern bit.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic               inp,
  input  logic               ovl,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic [LEN_W-1:0]   fill,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic               enabled;

  // Post-shift history/fill and the compare limited to the low len bits.
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], inp};
    fill_nxt = (fill < len) ? fill + LEN_W'(1) : len;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    enabled  = (len >= LEN_W'(2));
    hit      = shift && enabled && (fill_nxt == len) &&
               (((hist_nxt ^ pat) & mask) == '0);
  end

  // Shift on consumed bits; non-overlap detections restart the fill count.
  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      if (hit && !ovl) fill <= '0;
      else             fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Configurable serial pattern detector: holds configuration, the registered
// match pulse and a saturating match counter around the history window.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
  parameter int CNT_W   = seq_det_pkg::CNT_W
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         inp,
  input  logic                         in_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pat,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(MAX_LEN+1)-1:0] fill
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [LEN_W-1:0]   len_clamped;
  logic               shift;
  logic               hit;

  // A bit arriving together with a configuration load is dropped.
  always_comb begin
    len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
    shift       = in_valid && !cfg_load;
  end

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .CLK   (CLK),
    .rst   (rst),
    .clear (cfg_load),
    .shift (shift),
    .inp   (inp),
    .ovl   (ovl_r),
    .pat   (pat_r),
    .len   (len_r),
    .fill  (fill),
    .hit   (hit)
  );

  // Configuration capture, one-cycle match pulse and saturating counter.
  always_ff @(posedge CLK) begin
    if (rst) begin
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b1;
      match       <= 1'b0;
      match_count <= '0;
    end else if (cfg_load) begin
      pat_r       <= cfg_pat;
      len_r       <= len_clamped;
      ovl_r       <= cfg_overlap;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= hit;
      if (hit && (match_count != '1)) match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: a bit-queue reference model
// pushes expected outputs per edge; each test pops and compares inline.
module tb_seq_detect_param;

  logic        CLK;
  logic        rst;
  logic        inp;
  logic        in_valid;
  logic        cfg_load;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        match;
  logic [15:0] match_count;
  logic [3:0]  fill;
  logic        match_s;
  logic [3:0]  match_count_s;
  logic [3:0]  fill_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic m;
    int   count;
    int   fill;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_pat;
  int          m_len;
  logic        m_ovl;
  int          m_fill;
  int          m_count;
  logic        m_bits[$];

  seq_detect_param #(.MAX_LEN(8), .CNT_W(16)) dut (
    .CLK(CLK), .rst(rst), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .match(match), .match_count(match_count), .fill(fill)
  );

  seq_detect_param #(.MAX_LEN(8), .CNT_W(4)) dut_sat (
    .CLK(CLK), .rst(rst), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .match(match_s), .match_count(match_count_s), .fill(fill_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model for one edge without reset or load.
  task automatic modelBit(input logic v, input logic b);
    exp_t e;
    logic det;
    det = 1'b0;
    if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      m_fill = (m_fill < m_len) ? m_fill + 1 : m_len;
      if (m_len >= 2 && m_fill == m_len) begin
        det = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] !== m_pat[k]) det = 1'b0;
      end
      if (det) begin
        if (m_count < 65535) m_count++;
        if (!m_ovl) m_fill = 0;
      end
    end
    e.m = det; e.count = m_count; e.fill = m_fill;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic b);
    in_valid = v;
    inp      = b;
    cfg_load = 1'b0;
    modelBit(v, b);
    @(posedge CLK);
    #1;
  endtask

  task automatic doLoad(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic v, input logic b);
    exp_t e;
    cfg_load = 1'b1; cfg_pat = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; inp = b;
    m_pat = p; m_len = (l > 8) ? 8 : int'(l); m_ovl = o;
    m_fill = 0; m_count = 0; m_bits.delete();
    e.m = 1'b0; e.count = 0; e.fill = 0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic doReset(input logic v, input logic b);
    exp_t e;
    rst = 1'b1; cfg_load = 1'b1; in_valid = v; inp = b;
    m_pat = '0; m_len = 0; m_ovl = 1'b1; m_fill = 0; m_count = 0;
    m_bits.delete();
    e.m = 1'b0; e.count = 0; e.fill = 0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    rst = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    doReset(1'b1, 1'b1);
    e = sb.pop_front();
    n_checks += 4;
    if (match !== e.m) begin n_fail++; $display("[TB] FAIL reset match: got %0b, expected %0b", match, e.m); end
    if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL reset count: got %0d, expected %0d", match_count, e.count); end
    if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL reset fill: got %0d, expected %0d", fill, e.fill); end
    if (match_count_s !== 4'd0) begin n_fail++; $display("[TB] FAIL reset sat count: got %0d, expected 0", match_count_s); end
    // Detection is disabled until a configuration is loaded.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      e = sb.pop_front();
      n_checks += 1;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL unconfigured match bit %0d: got %0b, expected %0b", i, match, e.m); end
    end
  endtask

  task automatic test_stream(input string tag, input logic o, input int want_count, input int want_fill);
    exp_t e;
    logic [7:0] s;
    s = 8'b10110110;
    doLoad(8'b10110, 4'd5, o, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, s[7-i]);
      e = sb.pop_front();
      n_checks += 3;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL %s match bit %0d: got %0b, expected %0b", tag, i + 1, match, e.m); end
      if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL %s count bit %0d: got %0d, expected %0d", tag, i + 1, match_count, e.count); end
      if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL %s fill bit %0d: got %0d, expected %0d", tag, i + 1, fill, e.fill); end
    end
    n_checks += 2;
    if (match_count !== 16'(want_count)) begin n_fail++; $display("[TB] FAIL %s final count: got %0d, expected %0d", tag, match_count, want_count); end
    if (fill !== 4'(want_fill)) begin n_fail++; $display("[TB] FAIL %s final fill: got %0d, expected %0d", tag, fill, want_fill); end
  endtask

  task automatic test_gaps();
    exp_t e;
    logic [10:0] vv;
    logic [10:0] bb;
    int pulses;
    vv = 11'b111_000_11111;
    bb = 11'b101_101_10110;
    pulses = 0;
    doLoad(8'b10110, 4'd5, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vv[10-i], bb[10-i]);
      e = sb.pop_front();
      if (match === 1'b1) pulses++;
      n_checks += 2;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL gaps match edge %0d: got %0b, expected %0b", i, match, e.m); end
      if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL gaps fill edge %0d: got %0d, expected %0d", i, fill, e.fill); end
    end
    n_checks += 2;
    if (pulses != 2) begin n_fail++; $display("[TB] FAIL gaps pulses: got %0d, expected 2", pulses); end
    if (match_count !== 16'd2) begin n_fail++; $display("[TB] FAIL gaps count: got %0d, expected 2", match_count); end
  endtask

  task automatic test_load_priority();
    exp_t e;
    logic [8:0] s;
    s = 9'b1011_10110;
    doLoad(8'b10110, 4'd5, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, s[8-i]);
      void'(sb.pop_front());
    end
    // The final pattern bit arrives with the reload and must be dropped.
    doLoad(8'b10110, 4'd5, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks += 3;
    if (match !== e.m) begin n_fail++; $display("[TB] FAIL reload match: got %0b, expected %0b", match, e.m); end
    if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL reload count: got %0d, expected %0d", match_count, e.count); end
    if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL reload fill: got %0d, expected %0d", fill, e.fill); end
    for (int i = 4; i < 9; i++) begin
      applyStimulus(1'b1, s[8-i]);
      e = sb.pop_front();
      n_checks += 2;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL reload stream match bit %0d: got %0b, expected %0b", i, match, e.m); end
      if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL reload stream fill bit %0d: got %0d, expected %0d", i, fill, e.fill); end
    end
    n_checks += 1;
    if (match_count !== 16'd1) begin n_fail++; $display("[TB] FAIL reload final count: got %0d, expected 1", match_count); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [4:0] s;
    int pulses;
    s = 5'b10110;
    pulses = 0;
    doLoad(8'b10110, 4'd5, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, s[4-i]);
      void'(sb.pop_front());
    end
    doReset(1'b1, 1'b0);
    e = sb.pop_front();
    n_checks += 3;
    if (match !== e.m) begin n_fail++; $display("[TB] FAIL midreset match: got %0b, expected %0b", match, e.m); end
    if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL midreset count: got %0d, expected %0d", match_count, e.count); end
    if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL midreset fill: got %0d, expected %0d", fill, e.fill); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, s[4-i]);
      e = sb.pop_front();
      if (match === 1'b1) pulses++;
      n_checks += 1;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL midreset stream match bit %0d: got %0b, expected %0b", i, match, e.m); end
    end
    n_checks += 1;
    if (pulses != 0) begin n_fail++; $display("[TB] FAIL midreset pulses: got %0d, expected 0", pulses); end
  endtask

  task automatic test_disabled();
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      doLoad(8'h01, 4'(l), 1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 1'b1);
        e = sb.pop_front();
        n_checks += 3;
        if (match !== e.m) begin n_fail++; $display("[TB] FAIL len%0d match bit %0d: got %0b, expected %0b", l, i, match, e.m); end
        if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL len%0d count bit %0d: got %0d, expected %0d", l, i, match_count, e.count); end
        if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL len%0d fill bit %0d: got %0d, expected %0d", l, i, fill, e.fill); end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int want_s;
    doLoad(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1);
      e = sb.pop_front();
      want_s = (i > 15) ? 15 : i;
      n_checks += 4;
      if (match !== e.m) begin n_fail++; $display("[TB] FAIL b2b match bit %0d: got %0b, expected %0b", i + 1, match, e.m); end
      if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL b2b count bit %0d: got %0d, expected %0d", i + 1, match_count, e.count); end
      if (match_s !== (i >= 1)) begin n_fail++; $display("[TB] FAIL sat match bit %0d: got %0b, expected %0b", i + 1, match_s, (i >= 1)); end
      if (match_count_s !== 4'(want_s)) begin n_fail++; $display("[TB] FAIL sat count bit %0d: got %0d, expected %0d", i + 1, match_count_s, want_s); end
    end
  endtask

  task automatic test_clamp();
    exp_t e;
    doLoad(8'hFF, 4'd11, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1);
      e = sb.pop_front();
      n_checks += 3;
      if (match !== (i >= 7)) begin n_fail++; $display("[TB] FAIL clamp match bit %0d: got %0b, expected %0b", i + 1, match, (i >= 7)); end
      if (match_count !== 16'(e.count)) begin n_fail++; $display("[TB] FAIL clamp count bit %0d: got %0d, expected %0d", i + 1, match_count, e.count); end
      if (fill !== 4'(e.fill)) begin n_fail++; $display("[TB] FAIL clamp fill bit %0d: got %0d, expected %0d", i + 1, fill, e.fill); end
    end
  endtask

  initial begin
    rst = 1'b1; inp = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
    @(posedge CLK);
    #1;
    $display("[TB] starting seq_detect_param tests");
    test_reset();
    test_stream("overlap", 1'b1, 2, 5);
    test_stream("nonoverlap", 1'b0, 1, 3);
    test_gaps();
    test_load_priority();
    test_reset_mid();
    test_disabled();
    test_saturation();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the match counter.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port inp  input  1  SHALL be the serial data bit.
REQ-006 Port in_valid  input  1  SHALL qualify inp; a bit is consumed only on an edge where in_valid=1.
REQ-007 Port cfg_load  input  1  SHALL load the configuration on the current edge.
REQ-008 Port cfg_pat  input  MAX_LEN  SHALL be the pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
REQ-009 Port cfg_len  input  $clog2(MAX_LEN+1)  SHALL be the pattern length.
REQ-010 Port cfg_overlap  input  1  SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-011 Port match  output  1  SHALL be a registered one-cycle pulse flagging a detected pattern.
REQ-012 Port match_count  output  CNT_W  SHALL count detections since the last reset or cfg_load.
REQ-013 Port fill  output  $clog2(MAX_LEN+1)  SHALL report the number of valid history bits, saturating at the active length.

Function
REQ-014 Config registers pat_r, len_r and ovl_r SHALL capture cfg_pat, cfg_len and cfg_overlap on an edge with cfg_load=1.
REQ-015 The same cfg_load edge SHALL clear history, fill, match_count and match.
REQ-016 cfg_load SHALL have priority over in_valid; a bit presented on a cfg_load edge SHALL be discarded.
REQ-017 A cfg_len greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-018 A cfg_len of 0 or 1 SHALL disable detection: match stays 0 and count holds.
REQ-019 On each consumed bit, history SHALL shift left with inp entering bit [0], and fill SHALL increment, saturating at len_r.
REQ-020 A detection SHALL occur on the consuming edge when the post-shift fill equals len_r and the post-shift history[len_r-1:0] equals pat_r[len_r-1:0].
REQ-021 On a detection edge, match SHALL be 1 for exactly the following cycle; latency is 0 edges after the final bit.
REQ-022 match SHALL be 0 in every cycle that follows an edge without a detection, including edges with in_valid=0.
REQ-023 Overlap mode (ovl_r=1): after a detection, history and fill SHALL be retained.
REQ-024 Non-overlap mode (ovl_r=0): a detection SHALL clear fill to 0, so the next match needs len_r fresh bits.
REQ-025 match_count SHALL increment by 1 per detection and saturate at all-ones; it SHALL never wrap.
REQ-026 Back-to-back detections on consecutive consuming edges SHALL each produce a pulse; match stays high for both cycles.
REQ-027 History bits above len_r-1 SHALL be ignored in the compare.

Reset
REQ-028 With rst=1 at an edge, the block SHALL load history=0, fill=0, match=0, match_count=0, pat_r=0, len_r=0 and ovl_r=1; detection is disabled until cfg_load.
REQ-029 rst SHALL take priority over cfg_load and in_valid; a reset mid-pattern SHALL discard the partial history.

Structure
REQ-030 Package seq_det_pkg SHALL hold MAX_LEN, CNT_W, the derived LEN_W=$clog2(MAX_LEN+1), and the length-clamp function.
REQ-031 Sub-module seq_det_window SHALL implement the shift register, fill counter and masked compare; the top holds config, the counter and the match register.

Verification
REQ-032 Load pat=5'b10110, len=5, overlap=1, then stream 1,0,1,1,0,1,1,0 -> match after bits 5 and 8, match_count=2.
REQ-033 Repeat REQ-032 with overlap=0 -> match after bit 5 only, match_count=1, fill=3 at end.
REQ-034 Toggle in_valid=0 for 3 edges mid-pattern with garbage on inp -> detections identical to REQ-032.
REQ-035 Assert cfg_load with in_valid=1 after 4 correct bits -> fill=0, count=0, no match, bit discarded; assert rst after 4 bits -> all outputs 0.
REQ-036 CNT_W=4, pattern 2'b11, overlap=1, stream of 20 ones -> match high from bit 2 onward, count saturates at 4'hF.
REQ-037 cfg_len=MAX_LEN+3 with an all-ones pattern -> length clamps to MAX_LEN; first match after MAX_LEN ones.
